// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder slice reused LSB-first over WIDTH cycles,
// with the carry held in a flop and the sum collected in a shift register.
module serial_adder_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | ((a ^ b) & ci);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             c_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh;
    logic             cy;
    logic [CW-1:0]    cnt;
    logic             s, co;

    serial_adder_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (cy),
        .s  (s),
        .co (co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            cy      <= 1'b0;
            cnt     <= '0;
            sum_out <= '0;
            c_out   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a_in;
                    b_sh  <= b_in;
                    cy    <= c_in;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    s_sh <= {s, s_sh[WIDTH-1:1]};
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    cy   <= co;
                    cnt  <= cnt + 1'b1;
                    // Final slice: publish the fully assembled sum in the same edge.
                    if (cnt == LAST) begin
                        sum_out <= {s, s_sh[WIDTH-1:1]};
                        c_out   <= co;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN) || (state == DONE);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 directed cases plus WIDTH=4 exhaustive sweep.
module tb_serial_adder;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st8, c8, busy8, done8, co8;
    logic [7:0] a8, b8, s8;
    logic       st4, c4, busy4, done4, co4;
    logic [3:0] a4, b4, s4;

    int n_vec = 0;
    int n_err = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a_in(a8), .b_in(b8), .c_in(c8),
        .busy(busy8), .done(done8), .sum_out(s8), .c_out(co8)
    );
    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(st4), .a_in(a4), .b_in(b4), .c_in(c4),
        .busy(busy4), .done(done4), .sum_out(s4), .c_out(co4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one WIDTH=8 op and wait for done; lat = edges from accept to done.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c, output int lat);
        @(negedge clk); st8 = 1'b1; a8 = a; b8 = b; c8 = c;
        @(posedge clk); #1; st8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                       input logic [4:0] prev);
        int lat;
        @(negedge clk); st4 = 1'b1; a4 = a; b4 = b; c4 = c;
        @(posedge clk); #1; st4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 12) begin
            chk("stable4", {59'd0, co4, s4}, {59'd0, prev});
            @(posedge clk); #1; lat++;
        end
        chk("lat4", lat, 4);
        chk("sum4", {59'd0, co4, s4}, {59'd0, 5'(a + b + c)});
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, ndone;
        logic [4:0] prev;
        logic [8:0] exp9;
        logic [7:0] ea, eb;
        logic       ec;
        rst = 1'b1; st8 = 0; a8 = 0; b8 = 0; c8 = 0; st4 = 0; a4 = 0; b4 = 0; c4 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", {co8, s8}, 9'h000);
        chk("rst_busy4", busy4, 0);
        @(negedge clk); rst = 1'b0;

        // Basic add, latency 8 edges after accept
        op8(8'h5A, 8'h3C, 1'b0, lat);
        chk("lat_5a3c", lat, 8);
        chk("busy_in_done", busy8, 1);
        chk("sum_5a3c", {co8, s8}, 9'h096);
        @(posedge clk); #1;
        chk("idle_after_done", {busy8, done8}, 2'b00);
        chk("hold_sum", {co8, s8}, 9'h096);

        op8(8'hFF, 8'h01, 1'b0, lat);
        chk("lat_ff01", lat, 8);
        chk("sum_ff01", {co8, s8}, 9'h100);
        @(posedge clk); #1;
        op8(8'hFF, 8'hFF, 1'b1, lat);
        chk("sum_ffff1", {co8, s8}, 9'h1FF);
        @(posedge clk); #1;

        // start pulses in RUN and DONE must be ignored
        @(negedge clk); st8 = 1; a8 = 8'h5A; b8 = 8'h3C; c8 = 0;
        @(posedge clk); #1;
        ndone = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            st8 = (i == 3); a8 = 8'h01; b8 = 8'h01;
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("ign_done_at8", done8, 1);
        @(negedge clk); st8 = 1;
        @(posedge clk); #1;
        @(negedge clk); st8 = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        chk("ign_one_done", ndone, 1);
        chk("ign_sum", {co8, s8}, 9'h096);

        // Reset at the 4th RUN edge aborts
        @(negedge clk); st8 = 1; a8 = 8'h80; b8 = 8'h80; c8 = 0;
        @(posedge clk); #1; st8 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1;
        @(posedge clk); #1;
        @(negedge clk); rst = 0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_busy", busy8, 0);
        chk("abort_sum", {co8, s8}, 9'h000);
        op8(8'h12, 8'h34, 1'b0, lat);
        chk("after_abort_sum", {co8, s8}, 9'h046);
        @(posedge clk); #1;

        // start held high: accepts at edges 0,10,20; done at 8,18,28
        ndone = 0;
        for (int e = 0; e < 32; e++) begin
            @(negedge clk);
            st8 = 1; a8 = 8'(e * 7 + 3); b8 = 8'(e * 13 + 1); c8 = e[0];
            if (e % 10 == 0) begin ea = a8; eb = b8; ec = c8; end
            @(posedge clk); #1;
            if (e % 10 == 8) begin
                exp9 = {1'b0, ea} + {1'b0, eb} + {8'd0, ec};
                chk("cont_done", done8, 1);
                chk("cont_sum", {co8, s8}, exp9);
            end else if (done8) ndone++;
        end
        chk("cont_stray_done", ndone, 0);
        @(negedge clk); st8 = 0;
        repeat (12) @(posedge clk);
        #1;

        // Exhaustive WIDTH=4
        prev = {co4, s4};
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    op4(4'(a), 4'(b), c[0], prev);
                    prev = 5'(a + b + c);
                end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
